// File: rtl/noc_pkg.sv
// Shared widths, flit field positions and FSM state type for the NoC send network interface.
`timescale 1ns/1ps
package noc_pkg;
    localparam int FLIT_W = 71;
    localparam int DATA_W = 64;
    localparam int DEST_W = 4;
    localparam int CRED_W = 2;

    localparam int FLIT_VALID_BIT = 70;
    localparam int FLIT_TAIL_BIT  = 69;
    localparam int FLIT_DEST_HI   = 68;
    localparam int FLIT_DEST_LO   = 65;
    localparam int FLIT_VC_BIT    = 64;
    localparam int FLIT_DATA_HI   = 63;
    localparam int FLIT_DATA_LO   = 0;

    localparam int CRED_VALID_BIT = 1;
    localparam int CRED_VC_BIT    = 0;

    localparam logic [DEST_W-1:0] MAX_DEST = 4'd8;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } ni_state_t;

    // Every flit is a single head+tail flit.
    function automatic logic [FLIT_W-1:0] make_flit(
        input logic [DEST_W-1:0] dest,
        input logic              vc,
        input logic [DATA_W-1:0] data
    );
        make_flit = {1'b1, 1'b1, dest, vc, data};
    endfunction
endpackage

// File: rtl/noc_ni_fifo.sv
// Word FIFO for the send NI: power-of-two depth, pointer-MSB full/empty detection.
`timescale 1ns/1ps
module noc_ni_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEST_W + DATA_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointers; reset flushes the contents.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end
endmodule

// File: rtl/noc_send_ni.sv
// Send-side network interface: buffers operator words and injects credit-controlled single flits.
// Optional sticky error output enabled by defining NOC_NI_ERR_EN.
`timescale 1ns/1ps
module noc_send_ni
    import noc_pkg::*;
#(
    parameter int NUM_CREDITS = 4,
    parameter int VC          = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_en,
    input  logic [CRED_W-1:0] credit_in,
    output logic              credit_en,
    output logic [3:0]        credits,
    output logic [15:0]       sent_cnt
`ifdef NOC_NI_ERR_EN
    ,
    output logic              err
`endif
);
    localparam logic       L_VC       = 1'(VC);
    localparam logic [3:0] L_MAX_CRED = 4'(NUM_CREDITS);

    ni_state_t                  r_state;
    ni_state_t                  w_state_nxt;
    logic [3:0]                 r_credits;
    logic [3:0]                 w_credits_nxt;
    logic [FLIT_W-1:0]          r_flit;
    logic                       r_flit_en;
    logic [15:0]                r_sent_cnt;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;
    logic [DEST_W+DATA_W-1:0]   w_fifo_rdata;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_cred_ret;

    assign in_ready   = (r_state != ST_INIT) && !w_fifo_full;
    assign credit_en  = (r_state != ST_INIT);
    assign w_push     = in_valid && in_ready;
    assign w_pop      = (r_state == ST_RUN) && !w_fifo_empty && (r_credits != 4'd0);
    assign w_cred_ret = (r_state != ST_INIT) && credit_in[CRED_VALID_BIT] &&
                        (credit_in[CRED_VC_BIT] == L_VC);

    assign flit_out = r_flit;
    assign flit_en  = r_flit_en;
    assign credits  = r_credits;
    assign sent_cnt = r_sent_cnt;

    noc_ni_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DEST_W + DATA_W)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_wdata ({in_dest, in_data}),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Next-state and credit accounting; a send and a matching return on one edge cancel.
    always_comb begin
        w_state_nxt   = r_state;
        w_credits_nxt = r_credits;
        case (r_state)
            ST_INIT: begin
                w_state_nxt   = ST_RUN;
                w_credits_nxt = L_MAX_CRED;
            end
            ST_RUN: begin
                if (w_pop && w_cred_ret) begin
                    w_credits_nxt = r_credits;
                end else if (w_pop) begin
                    w_credits_nxt = r_credits - 4'd1;
                    if (r_credits == 4'd1) begin
                        w_state_nxt = ST_STALL;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (w_cred_ret && (r_credits != L_MAX_CRED)) begin
                    w_credits_nxt = r_credits + 4'd1;
                end else begin
                    w_credits_nxt = r_credits;
                end
            end
            ST_STALL: begin
                if (w_cred_ret) begin
                    w_credits_nxt = r_credits + 4'd1;
                    w_state_nxt   = ST_RUN;
                end else begin
                    w_state_nxt   = ST_STALL;
                end
            end
            default: begin
                w_state_nxt   = ST_INIT;
                w_credits_nxt = 4'd0;
            end
        endcase
    end

    // State, credit counter, registered flit output and injection counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_INIT;
            r_credits  <= 4'd0;
            r_flit     <= {FLIT_W{1'b0}};
            r_flit_en  <= 1'b0;
            r_sent_cnt <= 16'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_credits <= w_credits_nxt;
            r_flit_en <= w_pop;
            if (w_pop) begin
                r_flit     <= make_flit(w_fifo_rdata[DEST_W+DATA_W-1:DATA_W], L_VC,
                                        w_fifo_rdata[DATA_W-1:0]);
                r_sent_cnt <= r_sent_cnt + 16'd1;
            end else begin
                r_flit     <= {FLIT_W{1'b0}};
            end
        end
    end

`ifdef NOC_NI_ERR_EN
    logic r_err;
    logic w_cred_drop;

    assign w_cred_drop = (r_state == ST_RUN) && w_cred_ret && !w_pop &&
                         (r_credits == L_MAX_CRED);
    assign err = r_err;

    // Sticky error: credit overflow or out-of-range destination.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_cred_drop || (w_push && (in_dest > MAX_DEST))) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end
`endif
endmodule

// File: tb/tb_noc_send_ni.sv
// Self-checking bench for noc_send_ni: directed scenarios plus randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_noc_send_ni;
    localparam int   NUM    = 4;
    localparam int   DEPTH  = 4;
    localparam logic VC_BIT = 1'b0;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [3:0]  in_dest;
    logic [70:0] flit_out;
    logic        flit_en;
    logic [1:0]  credit_in;
    logic        credit_en;
    logic [3:0]  credits;
    logic [15:0] sent_cnt;
`ifdef NOC_NI_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: queued words, credit count, init-pending flag.
    logic [67:0] m_q[$];
    int          m_credits = 0;
    bit          m_init = 1'b1;
    logic [70:0] m_flit = '0;
    logic        m_en = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_err = 1'b0;

    noc_send_ni #(.NUM_CREDITS(NUM), .VC(0), .FIFO_DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .flit_out  (flit_out),
        .flit_en   (flit_en),
        .credit_in (credit_in),
        .credit_en (credit_en),
        .credits   (credits),
        .sent_cnt  (sent_cnt)
`ifdef NOC_NI_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance the model with the current inputs, then let the DUT take the same edge.
    task automatic step();
        bit          acc;
        bit          pop;
        bit          match;
        logic [67:0] head;
        if (RST) begin
            m_q.delete();
            m_init = 1'b1; m_credits = 0; m_flit = '0; m_en = 1'b0;
            m_cnt = 16'd0; m_err = 1'b0;
        end else begin
            acc   = in_valid && !m_init && (m_q.size() < DEPTH);
            pop   = !m_init && (m_q.size() > 0) && (m_credits > 0);
            match = !m_init && (credit_in == {1'b1, VC_BIT});
            if (m_init) begin
                m_credits = NUM;
                m_init    = 1'b0;
            end else if (pop && !match) begin
                m_credits = m_credits - 1;
            end else if (!pop && match) begin
                if (m_credits == NUM) m_err = 1'b1;
                else m_credits = m_credits + 1;
            end
            if (pop) begin
                head   = m_q.pop_front();
                m_flit = {1'b1, 1'b1, head[67:64], VC_BIT, head[63:0]};
                m_en   = 1'b1;
                m_cnt  = m_cnt + 16'd1;
            end else begin
                m_flit = '0;
                m_en   = 1'b0;
            end
            if (acc) begin
                m_q.push_back({in_dest, in_data});
                if (in_dest > 4'd8) m_err = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; in_valid = 1'b0; credit_in = 2'b00;
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b0; in_data = 64'd0; in_dest = 4'd0; credit_in = 2'b00;
        step(); step();
        checks++; if (flit_en !== 1'b0) begin errors++; $display("FAIL reset_flit_en got %b want 0", flit_en); end
        checks++; if (flit_out !== 71'd0) begin errors++; $display("FAIL reset_flit_out got %h want 0", flit_out); end
        checks++; if (credit_en !== 1'b0) begin errors++; $display("FAIL reset_credit_en got %b want 0", credit_en); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (credits !== 4'd0) begin errors++; $display("FAIL reset_credits got %0d want 0", credits); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL reset_sent_cnt got %0d want 0", sent_cnt); end
        RST = 1'b0;
        step();
        checks++; if (credits !== 4'd4) begin errors++; $display("FAIL init_credits got %0d want 4", credits); end
        checks++; if (credit_en !== 1'b1) begin errors++; $display("FAIL init_credit_en got %b want 1", credit_en); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL init_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        RST = 1'b1; in_valid = 1'b0; credit_in = 2'b00;
        step();
        RST = 1'b0; in_valid = 1'b1; in_data = 64'd13; in_dest = 4'd7;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_init_ready got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_run_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (flit_en !== 1'b0) begin errors++; $display("FAIL single_early_flit got %b want 0", flit_en); end
        step();
        checks++; if (flit_en !== 1'b1) begin errors++; $display("FAIL single_flit_en got %b want 1", flit_en); end
        checks++; if (flit_out !== {1'b1, 1'b1, 4'b0111, 1'b0, 64'd13}) begin errors++; $display("FAIL single_flit_out got %h want %h", flit_out, {1'b1, 1'b1, 4'b0111, 1'b0, 64'd13}); end
        checks++; if (credits !== 4'd3) begin errors++; $display("FAIL single_credits got %0d want 3", credits); end
        step();
        checks++; if (flit_out !== 71'd0 || flit_en !== 1'b0) begin errors++; $display("FAIL single_idle got %h/%b want 0/0", flit_out, flit_en); end
    endtask

    task automatic test_stall();
        logic [67:0] words[8];
        int          nflits;
        nflits = 0;
        do_reset();
        for (int i = 0; i < 8; i++) words[i] = {4'($urandom_range(0, 8)), $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 6);
            if (i < 6) begin in_dest = words[i][67:64]; in_data = words[i][63:0]; end
            step();
            if (flit_en === 1'b1) begin
                checks++;
                if (flit_out !== {1'b1, 1'b1, words[nflits][67:64], VC_BIT, words[nflits][63:0]}) begin
                    errors++; $display("FAIL stall_flit%0d got %h", nflits, flit_out);
                end
                nflits++;
            end
        end
        checks++; if (nflits != 4) begin errors++; $display("FAIL stall_nflits got %0d want 4", nflits); end
        checks++; if (credits !== 4'd0) begin errors++; $display("FAIL stall_credits got %0d want 0", credits); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready got %b want 1", in_ready); end
        checks++; if (sent_cnt !== 16'd4) begin errors++; $display("FAIL stall_sent_cnt got %0d want 4", sent_cnt); end
        // Two more words fill the 4-deep FIFO only if it was holding 2.
        for (int i = 6; i < 8; i++) begin
            in_valid = 1'b1; in_dest = words[i][67:64]; in_data = words[i][63:0];
            step();
        end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %b want 0", in_ready); end
        credit_in = 2'b10;
        step();
        credit_in = 2'b00;
        checks++; if (credits !== 4'd1 || flit_en !== 1'b0) begin errors++; $display("FAIL stall_resume got cr=%0d en=%b want 1/0", credits, flit_en); end
        step();
        checks++; if (flit_en !== 1'b1 || flit_out !== {1'b1, 1'b1, words[4][67:64], VC_BIT, words[4][63:0]}) begin
            errors++; $display("FAIL stall_fifth got %b %h", flit_en, flit_out);
        end
        checks++; if (credits !== 4'd0) begin errors++; $display("FAIL stall_fifth_credits got %0d want 0", credits); end
    endtask

    task automatic test_credit_filter();
        do_reset();
        in_valid = 1'b1; in_dest = 4'd3; in_data = 64'hA5;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (credits !== 4'd3) begin errors++; $display("FAIL filt_start got %0d want 3", credits); end
        credit_in = 2'b11; step();
        checks++; if (credits !== 4'd3) begin errors++; $display("FAIL filt_wrong_vc got %0d want 3", credits); end
        credit_in = 2'b00; step();
        credit_in = 2'b01; step();
        checks++; if (credits !== 4'd3) begin errors++; $display("FAIL filt_invalid got %0d want 3", credits); end
        credit_in = 2'b10; step();
        checks++; if (credits !== 4'd4) begin errors++; $display("FAIL filt_return got %0d want 4", credits); end
`ifdef NOC_NI_ERR_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL filt_err_pre got %b want 0", err); end
`endif
        step();
        credit_in = 2'b00;
        checks++; if (credits !== 4'd4) begin errors++; $display("FAIL filt_saturate got %0d want 4", credits); end
`ifdef NOC_NI_ERR_EN
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL filt_err got %b want 1", err); end
`endif
    endtask

    task automatic test_same_edge();
        do_reset();
        in_valid = 1'b1; in_dest = 4'd1; in_data = 64'd100;
        step();
        in_data = 64'd101;
        step();
        in_valid = 1'b0;
        step();
        checks++; if (credits !== 4'd2) begin errors++; $display("FAIL same_start got %0d want 2", credits); end
        in_valid = 1'b1; in_data = 64'd102;
        step();
        in_valid = 1'b0; credit_in = 2'b10;
        step();
        credit_in = 2'b00;
        checks++; if (flit_en !== 1'b1) begin errors++; $display("FAIL same_flit_en got %b want 1", flit_en); end
        checks++; if (credits !== 4'd2) begin errors++; $display("FAIL same_credits got %0d want 2", credits); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_dest = 4'd2; in_data = 64'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        credit_in = 2'b10;
        step();
        credit_in = 2'b00;
        checks++; if (credits !== 4'd1) begin errors++; $display("FAIL mid_pre_credits got %0d want 1", credits); end
        RST = 1'b1;
        step();
        checks++; if (flit_en !== 1'b0) begin errors++; $display("FAIL mid_flit_en got %b want 0", flit_en); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
        RST = 1'b0;
        step();
        checks++; if (credits !== 4'd4) begin errors++; $display("FAIL mid_credits got %0d want 4", credits); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL mid_sent_cnt got %0d want 0", sent_cnt); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (flit_en !== 1'b0) begin errors++; $display("FAIL mid_stale_flit cyc %0d got %b", i, flit_en); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            RST       = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 1);
            in_data   = {$urandom, $urandom};
            in_dest   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            credit_in = 2'($urandom_range(0, 3));
            step();
            checks++; if (flit_out !== m_flit) begin errors++; $display("FAIL rnd_flit_out cyc %0d got %h want %h", c, flit_out, m_flit); end
            checks++; if (flit_en !== m_en) begin errors++; $display("FAIL rnd_flit_en cyc %0d got %b want %b", c, flit_en, m_en); end
            checks++; if (credits !== 4'(m_credits)) begin errors++; $display("FAIL rnd_credits cyc %0d got %0d want %0d", c, credits, m_credits); end
            checks++; if (sent_cnt !== m_cnt) begin errors++; $display("FAIL rnd_sent_cnt cyc %0d got %0d want %0d", c, sent_cnt, m_cnt); end
            checks++; if (in_ready !== (!m_init && (m_q.size() < DEPTH))) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %b", c, in_ready); end
            checks++; if (credit_en !== !m_init) begin errors++; $display("FAIL rnd_credit_en cyc %0d got %b", c, credit_en); end
`ifdef NOC_NI_ERR_EN
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %b", c, err, m_err); end
`endif
        end
        RST = 1'b0; in_valid = 1'b0; credit_in = 2'b00;
    endtask

    task automatic test_wrap();
        int          n;
        int          cyc;
        logic [15:0] prev;
        n = 0; cyc = 0; prev = 16'h0;
        do_reset();
        in_valid = 1'b1; credit_in = 2'b10;
        while (n < 65536 && cyc < 70000) begin
            in_data = {32'h0, cyc};
            in_dest = 4'(cyc % 9);
            step();
            cyc++;
            if (flit_en === 1'b1) begin
                n++;
                if (n == 65535) prev = sent_cnt;
            end
        end
        in_valid = 1'b0; credit_in = 2'b00;
        checks++; if (n != 65536) begin errors++; $display("FAIL wrap_timeout flits %0d want 65536", n); end
        checks++; if (prev !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre got %h want ffff", prev); end
        checks++; if (sent_cnt !== 16'd0) begin errors++; $display("FAIL wrap_sent_cnt got %h want 0", sent_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_credit_filter();
        test_same_edge();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/noc_send_ni.md
NOC_SEND_NI -- requirements
Module: noc_send_ni

Interface
REQ-001 SHALL have parameter NUM_CREDITS, default 4, meaning router input-buffer slots per VC (1..15).
REQ-002 SHALL have parameter VC, default 0, meaning the virtual channel (0/1) stamped on every flit and matched on credits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the local word-FIFO depth (power of 2, >=2).
REQ-004 SHALL have a single clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  clock; all state updates on rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  operator word valid.
REQ-008 in_ready  out  1  NI can accept a word.
REQ-009 in_data  in  64  operator result.
REQ-010 in_dest  in  4  destination node id (0..8).
REQ-011 flit_out  out  71  to router putFlit: [70] valid, [69] tail, [68:65] dest, [64] vc, [63:0] data.
REQ-012 flit_en  out  1  router putFlit enable.
REQ-013 credit_in  in  2  from router getCredits: [1] valid, [0] vc.
REQ-014 credit_en  out  1  router getCredits enable.
REQ-015 credits  out  4  current credit count.
REQ-016 sent_cnt  out  16  flits injected since reset.

Function
REQ-017 SHALL accept a word {in_dest,in_data} at an edge where in_valid and in_ready are both 1; in_ready = FIFO not full.
REQ-018 SHALL run FSM INIT -> RUN <-> STALL; INIT lasts exactly one cycle after reset and loads credits = NUM_CREDITS.
REQ-019 In RUN, with FIFO non-empty and credits > 0, SHALL pop the head and register flit_out = {1,1,dest,VC,data}, flit_en = 1, visible the following cycle.
REQ-020 Otherwise flit_out SHALL be all-zero and flit_en 0 in that cycle.
REQ-021 Minimum latency: word accepted at edge k SHALL appear on flit_out after edge k+1.
REQ-022 Every flit SHALL be single-flit (head = tail, bit 69 = 1).
REQ-023 RUN -> STALL when a send drops credits to 0 with no same-cycle return; STALL -> RUN on the edge a matching credit arrives.
REQ-024 A credit counts only when credit_in[1] = 1 and credit_in[0] = VC; other credits SHALL be ignored.
REQ-025 Same-edge send and matching credit SHALL leave credits unchanged.
REQ-026 Credit return at credits = NUM_CREDITS SHALL be discarded (saturate).
REQ-027 credit_en SHALL be 1 in every cycle except INIT and reset.
REQ-028 sent_cnt SHALL increment per flit_en cycle and wrap 0xFFFF -> 0.
REQ-029 Simultaneous accept and pop on a full FIFO SHALL NOT occur (in_ready = 0); on a non-full FIFO both SHALL proceed in one edge.

Reset
REQ-030 On RST: FIFO flushed, FSM = INIT, credits = 0, flit_out = 0, flit_en = 0, credit_en = 0, in_ready = 0, sent_cnt = 0.
REQ-031 Reset mid-operation SHALL discard buffered words and outstanding credits; no flit SHALL be emitted in the cycle after the reset edge.

Configuration
REQ-032 Macro NOC_NI_ERR_EN SHALL, when defined, add output err (1 bit, reset 0), set sticky on a discarded credit (REQ-026) or an accepted word with in_dest > 8.
REQ-033 Without NOC_NI_ERR_EN, port err and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-034 Package noc_pkg SHALL hold FLIT_W = 71, DATA_W = 64, DEST_W = 4, CRED_W = 2, flit field bit positions and the FSM state typedef.
REQ-035 The FIFO SHALL be sub-module noc_ni_fifo (parameterised depth/width, full/empty flags).

Verification
REQ-036 Reset, then one word data = 13, dest = 7, VC = 0 -> INIT one cycle; flit_out = {1,1,0111,0,13} with flit_en = 1 two edges after accept; credits 4 -> 3.
REQ-037 Six back-to-back words, no credit return, NUM_CREDITS = 4 -> exactly 4 flits, state STALL, credits 0, FIFO holds 2, in_ready = 1; one credit 2'b10 -> fifth flit next cycle.
REQ-038 credit_in = 2'b11 with VC = 0 -> credits unchanged; 2'b10 at credits = 4 -> credits stay 4, err = 1 (with NOC_NI_ERR_EN).
REQ-039 Send and credit 2'b10 on the same edge at credits = 2 -> credits remain 2.
REQ-040 Assert RST with 3 words queued and credits = 1 -> next cycle flit_en = 0, in_ready = 0; after INIT, credits = 4, sent_cnt = 0, no stale flit.
REQ-041 Preload sent_cnt near wrap: 0xFFFF flits then one more -> sent_cnt = 0.
